// File: rtl/issue_pkg.sv
// Shared types and constants for the dispatch-queue issue stage.
package issue_pkg;

  // Instruction word width and the position of the 2-bit functional-unit class field.
  localparam int unsigned DE_instr_width = 32;
  localparam int unsigned FU_LSB         = 6;
  localparam int unsigned FU_W           = 2;

  // One reservation station per functional-unit class.
  localparam int unsigned NUM_FU = 4;

  typedef enum logic [FU_W-1:0] {
    ALU = 2'd0,
    MUL = 2'd1,
    LSU = 2'd2,
    BR  = 2'd3
  } fu_e;

  // One-hot select of the reservation station for a given class.
  function automatic logic [NUM_FU-1:0] fu_onehot(input fu_e c);
    return NUM_FU'(1) << c;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Per-reservation-station credit counter: tracks free RS entries.
module credit_counter
  import issue_pkg::*;
#(
  parameter int unsigned RS_DEPTH = 4,
  parameter int unsigned CRED_W   = $clog2(RS_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              inc,
  input  logic              dec,
  output logic [CRED_W-1:0] credit,
  output logic              ovf_c
);

  localparam logic [CRED_W-1:0] FULL = CRED_W'(RS_DEPTH);

  // A return while already full is an overflow; the credit itself saturates.
  always_comb begin
    ovf_c = inc && !dec && !flush && (credit == FULL);
  end

  // Flush refills every RS because the stations are flushed in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit <= FULL;
    end else if (flush) begin
      credit <= FULL;
    end else if (inc && !dec) begin
      if (credit != FULL) begin
        credit <= credit + CRED_W'(1);
      end
    end else if (dec && !inc) begin
      credit <= credit - CRED_W'(1);
    end
  end

endmodule

// File: rtl/dispatch_issue.sv
// In-order, credit-gated issue from the dispatch queue head to the reservation stations.
module dispatch_issue
  import issue_pkg::*;
#(
  parameter int unsigned RS_DEPTH = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned CRED_W   = $clog2(RS_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       q_empty,
  input  logic [DE_instr_width-1:0]  q_instr,
  output logic                       q_rd_en,
  input  logic                       flush,
  input  logic [NUM_FU-1:0]          rs_credit_ret,
  output logic [NUM_FU-1:0]          iss_valid,
  output logic [DE_instr_width-1:0]  iss_instr,
  output logic [NUM_FU*CRED_W-1:0]   credit,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic                       cred_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fu_e               w_cls;
  logic [CRED_W-1:0] w_head_cred;
  logic              w_issue;
  logic              w_stall;
  logic [NUM_FU-1:0] w_dec;
  logic [NUM_FU-1:0] w_ovf;

  // Decode the head class and look up its RS credit.
  always_comb begin
    w_cls       = fu_e'(q_instr[FU_LSB +: FU_W]);
    w_head_cred = '0;
    for (int i = 0; i < int'(NUM_FU); i++) begin
      if (w_cls == fu_e'(i)) begin
        w_head_cred = credit[i*CRED_W +: CRED_W];
      end
    end
  end

  // Issue only a valid head whose RS has room; reset and flush suppress the pop.
  always_comb begin
    w_issue = !q_empty && (w_head_cred != '0) && !flush && rst_n;
    w_stall = !q_empty && !w_issue && !flush;
    w_dec   = w_issue ? fu_onehot(w_cls) : '0;
    q_rd_en = w_issue;
  end

  for (genvar g = 0; g < int'(NUM_FU); g++) begin : g_cred
    credit_counter #(
      .RS_DEPTH (RS_DEPTH),
      .CRED_W   (CRED_W)
    ) u_credit (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .inc    (rs_credit_ret[g]),
      .dec    (w_dec[g]),
      .credit (credit[g*CRED_W +: CRED_W]),
      .ovf_c  (w_ovf[g])
    );
  end

  // Issue register, saturating stall counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_valid <= '0;
      iss_instr <= '0;
      stall_cnt <= '0;
      cred_err  <= 1'b0;
    end else begin
      iss_valid <= w_dec;
      if (w_issue) begin
        iss_instr <= q_instr;
      end
      if (w_stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (|w_ovf) begin
        cred_err <= 1'b1;
      end
    end
  end

endmodule
